// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures hSync/vSync timing and recovers pixel/line position and lock status.
// Latency: sync pin falling edge acted on 3 clk later; locked follows the state register.
// Backpressure: none; free-running monitor. Optional error counter: VGA_SYNC_RX_ERRCNT_EN.
module vga_sync_rx #(
  parameter int H_PERIOD_CLKS = 3200,
  parameter int H_TOL         = 2,
  parameter int V_LINES       = 525,
  parameter int CLK_PER_PIX   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hSync,
  input  logic        vSync,
  output logic        locked,
  output logic [9:0]  pix_x,
  output logic [9:0]  line_y,
  output logic [11:0] line_period,
  output logic [9:0]  frame_lines,
  output logic        frame_strobe,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {SEARCH, ALIGN, CONFIRM, LOCKED} stateT;

  localparam logic [12:0] PER_MAX = 13'(H_PERIOD_CLKS + H_TOL);
  localparam logic [12:0] PER_MIN = 13'(H_PERIOD_CLKS - H_TOL);
  localparam logic [9:0]  LINES_EXP = 10'(V_LINES);

  stateT       state, stateNext;
  logic [2:0]  hPipe, vPipe;   // [0] metastable, [1] synced, [2] previous synced
  logic        hEdge, vEdge;
  logic [11:0] hCnt;
  logic [9:0]  lineCnt;
  logic        badLineSeen;
  logic [12:0] periodMeas;
  logic [11:0] periodClamp;
  logic [11:0] pixFull;
  logic        lineBad;
  logic        frameGood;
  logic        syncLoss;

  assign hEdge = hPipe[2] & ~hPipe[1];
  assign vEdge = vPipe[2] & ~vPipe[1];

  // Synchronize both sync pins and keep the previous synced value for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      hPipe <= 3'b000;
      vPipe <= 3'b000;
    end else begin
      hPipe <= {hPipe[1:0], hSync};
      vPipe <= {vPipe[1:0], vSync};
    end
  end

  // Line measurement, line/frame checks and sync-loss detection
  always_comb begin
    periodMeas  = {1'b0, hCnt} + 13'd1;
    periodClamp = periodMeas[12] ? 12'hFFF : periodMeas[11:0];
    lineBad     = hEdge && (state != SEARCH) &&
                  ((periodMeas > PER_MAX) || (periodMeas < PER_MIN));
    // A bad line flagged in the same clk as vSync still belongs to the ending frame
    frameGood   = (lineCnt == LINES_EXP) && !badLineSeen && !lineBad;
    // Fires once, on the clk h_cnt steps onto its saturation value
    syncLoss    = (hCnt == 12'd4094) && !hEdge;
    pixFull     = hCnt / 12'(CLK_PER_PIX);
    pix_x       = (pixFull > 12'd1023) ? 10'd1023 : pixFull[9:0];
  end

  // Lock state machine: next-state selection
  always_comb begin
    stateNext = state;
    if (syncLoss) begin
      stateNext = SEARCH;
    end else begin
      case (state)
        SEARCH:  if (vEdge) stateNext = ALIGN;
        ALIGN:   if (vEdge && frameGood) stateNext = CONFIRM;
        CONFIRM: if (vEdge) stateNext = frameGood ? LOCKED : ALIGN;
        LOCKED:  if (lineBad || (vEdge && !frameGood)) stateNext = ALIGN;
        default: stateNext = SEARCH;
      endcase
    end
  end

  // Lock state register
  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= stateNext;
  end

  assign locked = (state == LOCKED);
  assign line_y = lineCnt;

  // Horizontal counter, line counter and captured measurements
  always_ff @(posedge clk) begin
    if (reset) begin
      hCnt         <= 12'd0;
      lineCnt      <= 10'd0;
      badLineSeen  <= 1'b0;
      line_period  <= 12'd0;
      frame_lines  <= 10'd0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= vEdge;
      if (hEdge) begin
        hCnt        <= 12'd0;
        line_period <= periodClamp;
      end else if (hCnt != 12'hFFF) begin
        hCnt <= hCnt + 12'd1;
      end
      // vSync wins over a coincident hSync edge: the line is not counted
      if (syncLoss || vEdge) begin
        lineCnt <= 10'd0;
      end else if (hEdge && lineCnt != 10'h3FF) begin
        lineCnt <= lineCnt + 10'd1;
      end
      if (vEdge) frame_lines <= lineCnt;
      if (syncLoss || vEdge) badLineSeen <= 1'b0;
      else if (lineBad)      badLineSeen <= 1'b1;
    end
  end

`ifdef VGA_SYNC_RX_ERRCNT_EN
  logic       firstFrame;
  logic       errEvent;
  logic [7:0] errCnt;

  // One error per clk at most; the frame that starts on leaving SEARCH is exempt
  always_comb begin
    errEvent = (state != SEARCH) &&
               (syncLoss || lineBad || (vEdge && !frameGood && !firstFrame));
  end

  // Track the first frame after SEARCH and count timing errors with saturation
  always_ff @(posedge clk) begin
    if (reset) begin
      firstFrame <= 1'b0;
      errCnt     <= 8'd0;
    end else begin
      if (syncLoss)   firstFrame <= 1'b0;
      else if (vEdge) firstFrame <= (state == SEARCH);
      if (errEvent && errCnt != 8'hFF) errCnt <= errCnt + 8'd1;
    end
  end

  assign err_count = errCnt;
`else
  assign err_count = 8'd0;
`endif

endmodule
